cpc_rom_loader: RTL and testbench

- Parametrised download-to-SDRAM loader for system and expansion ROMs.
- Converts the host ioctl byte stream into paced SDRAM write cycles on ce_ref, and throttles the host via ioctl_wait.
- Resolves the target page from the file index and extension; optionally replicates each byte across memory banks.
- Keeps a per-page "ROM present" bitmap that the CPU read path uses for open-bus masking.

---
 rtl/cpc_rom_pkg.sv | 37 +++
 rtl/cpc_ext_decode.sv | 56 +++++
 rtl/cpc_rom_loader.sv | 160 ++++++++++++++++
 tb/tb_cpc_rom_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpc_rom_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpc_rom_pkg
//  Purpose  : Shared constants, FSM state type and ASCII hex helper for the
//             ROM download loader.
//  Revision : 1.0  initial release
// ============================================================================
package cpc_rom_pkg;

  // Fixed target pages ({expansion bit, 8-bit page})
  localparam logic [8:0] PAGE_BOOT0  = 9'h000;
  localparam logic [8:0] PAGE_BASIC  = 9'h100;
  localparam logic [8:0] PAGE_AMSDOS = 9'h107;
  localparam logic [8:0] PAGE_MF2    = 9'h1FF;
  localparam logic [8:0] PAGE_BADEXT = 9'h1EE;
  localparam int         PAGE_OFS_W  = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Uppercase ASCII hex digit to {valid, value}; anything else is invalid.
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46)
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpc_ext_decode.sv
`default_nettype none
// ============================================================================
//  Module   : cpc_ext_decode
//  Purpose  : Decodes the two-character file extension into a base page and
//             the combo flag, captured on download start.
//  Revision : 1.0  initial release
// ============================================================================
module cpc_ext_decode
  import cpc_rom_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        capture,
  input  logic [15:0] file_ext,
  input  logic        combo_done,
  output logic [8:0]  base_page,
  output logic        combo
);

  logic [4:0] w_hi_nib;
  logic [4:0] w_lo_nib;
  logic [8:0] w_dec_page;
  logic       w_dec_combo;

  // Extension to page: hex digits override the nibbles of the bad-ext page
  always_comb begin
    w_hi_nib    = hex_nibble(file_ext[15:8]);
    w_lo_nib    = hex_nibble(file_ext[7:0]);
    w_dec_page  = PAGE_BADEXT;
    w_dec_combo = 1'b0;
    if (w_hi_nib[4]) w_dec_page[7:4] = w_hi_nib[3:0];
    if (w_lo_nib[4]) w_dec_page[3:0] = w_lo_nib[3:0];
    if (file_ext == 16'h5A5A) begin
      w_dec_page = 9'h000;
    end else if (file_ext == 16'h5A30) begin
      w_dec_page  = 9'h000;
      w_dec_combo = 1'b1;
    end
  end

  // Hold decoded values; a combo image jumps to the MF2 page after its first 16 KiB
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      base_page <= 9'h000;
      combo     <= 1'b0;
    end else if (capture) begin
      base_page <= w_dec_page;
      combo     <= w_dec_combo;
    end else if (combo_done) begin
      base_page <= PAGE_MF2;
      combo     <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpc_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cpc_rom_loader
//  Purpose  : Turns the host ioctl byte stream into ce_ref-paced SDRAM writes,
//             stalls the host while busy and tracks loaded expansion pages.
//  Revision : 1.0  initial release
// ============================================================================
module cpc_rom_loader
  import cpc_rom_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int PAGE_W = 9,
  parameter int BANKS  = 2,
  parameter int BANK_W = 1
)(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_ref,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  input  logic [15:0]       ioctl_file_ext,
  output logic              ioctl_wait,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BANK_W-1:0] mem_bank,
  output logic [7:0]        mem_din,
  input  logic [7:0]        map_addr,
  output logic              map_hit,
  output logic              busy
);

  state_t              r_state;
  logic                r_dl_prev;
  logic                r_rep;
  logic [255:0]        r_map;

  logic                w_start;
  logic                w_combo_done;
  logic [8:0]          w_base_page;
  logic                w_combo;
  logic [10:0]         w_block;
  logic [PAGE_W-1:0]   w_page;
  logic [BANK_W-1:0]   w_bank;
  logic                w_rep;
  logic                w_ok;
  logic [ADDR_W-1:0]   w_addr;

  assign w_start      = ioctl_download & ~r_dl_prev & (ioctl_index != 8'd0);
  assign w_block      = ioctl_addr[24:14];
  assign busy         = (r_state != ST_IDLE);
  assign w_combo_done = (r_state == ST_DONE) && w_combo &&
                        (mem_addr[PAGE_OFS_W-1:0] == {PAGE_OFS_W{1'b1}});

  cpc_ext_decode u_ext_decode (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .capture    (w_start),
    .file_ext   (ioctl_file_ext),
    .combo_done (w_combo_done),
    .base_page  (w_base_page),
    .combo      (w_combo)
  );

  // Download-level history for start-edge detection
  always_ff @(posedge clk_sys) begin
    if (reset) r_dl_prev <= 1'b0;
    else       r_dl_prev <= ioctl_download;
  end

  // Map the incoming byte to page, bank and replication mode
  always_comb begin
    w_page = '0;
    w_bank = '0;
    w_rep  = 1'b0;
    w_ok   = 1'b1;
    if (ioctl_index == 8'd0) begin
      w_ok = (w_block[10:3] == 8'd0);
      case (w_block[1:0])
        2'd0:    w_page = PAGE_BOOT0;
        2'd1:    w_page = PAGE_BASIC;
        2'd2:    w_page = PAGE_AMSDOS;
        default: w_page = PAGE_MF2;
      endcase
      w_bank = BANK_W'(w_block[2]);
    end else begin
      w_page = {w_base_page[8], w_base_page[7:0] + ioctl_addr[21:14]};
      w_rep  = (ioctl_index[7:6] == 2'b01) || (ioctl_index[5:0] != 6'd0);
      w_bank = w_rep ? '0 : BANK_W'(&ioctl_index[7:6]);
    end
    w_addr = '0;
    w_addr[ADDR_W-1]                     = w_page[PAGE_W-1];
    w_addr[PAGE_OFS_W+7:PAGE_OFS_W]      = w_page[7:0];
    w_addr[PAGE_OFS_W-1:0]               = ioctl_addr[PAGE_OFS_W-1:0];
  end

  // Write sequencer: latch byte, pace writes on ce_ref, step banks when replicating
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      ioctl_wait <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_bank   <= '0;
      mem_din    <= '0;
      r_rep      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ioctl_wr && w_ok) begin
            mem_addr   <= w_addr;
            mem_din    <= ioctl_dout;
            mem_bank   <= w_bank;
            r_rep      <= w_rep;
            ioctl_wait <= 1'b1;
            r_state    <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (ce_ref) begin
            mem_wr  <= 1'b1;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (ce_ref) begin
            mem_wr <= 1'b0;
            if (r_rep && (mem_bank < BANK_W'(BANKS-1))) begin
              mem_bank <= mem_bank + BANK_W'(1);
              r_state  <= ST_ARM;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          ioctl_wait <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Loaded-page bitmap and registered lookup for open-bus masking
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_map   <= '0;
      map_hit <= 1'b0;
    end else begin
      if ((r_state == ST_DONE) && mem_addr[ADDR_W-1])
        r_map[mem_addr[PAGE_OFS_W+7:PAGE_OFS_W]] <= 1'b1;
      map_hit <= r_map[map_addr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpc_rom_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cpc_rom_loader
//  Purpose  : Scoreboard bench for the ROM download loader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpc_rom_loader;

  logic        clk_sys        = 1'b0;
  logic        reset          = 1'b1;
  logic        ce_ref         = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr       = 1'b0;
  logic [24:0] ioctl_addr     = '0;
  logic [7:0]  ioctl_dout     = '0;
  logic [7:0]  ioctl_index    = '0;
  logic [15:0] ioctl_file_ext = '0;
  logic [7:0]  map_addr       = '0;
  logic        ioctl_wait;
  logic        mem_wr;
  logic [22:0] mem_addr;
  logic [0:0]  mem_bank;
  logic [7:0]  mem_din;
  logic        map_hit;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [22:0] addr;
    logic [0:0]  bank;
    logic [7:0]  data;
  } wr_t;

  wr_t  exp_q[$];
  logic prev_wr = 1'b0;

  cpc_rom_loader #(.ADDR_W(23), .PAGE_W(9), .BANKS(2), .BANK_W(1)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ce_ref         (ce_ref),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_file_ext (ioctl_file_ext),
    .ioctl_wait     (ioctl_wait),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_bank       (mem_bank),
    .mem_din        (mem_din),
    .map_addr       (map_addr),
    .map_hit        (map_hit),
    .busy           (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // SDRAM slot strobe: one cycle in four
  initial begin
    int n;
    n = 0;
    forever begin
      @(negedge clk_sys);
      n++;
      ce_ref = ((n % 4) == 0);
    end
  end

  // Write monitor: pop expected write on each mem_wr rise, check ce pacing
  initial begin
    wr_t e;
    forever begin
      @(posedge clk_sys);
      #1;
      if (!reset) begin
        if (mem_wr && !prev_wr) begin
          check("wr_rise_on_ce", ce_ref, 1);
          check("wait_during_wr", ioctl_wait, 1);
          check("wr_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", mem_addr, e.addr);
            check("wr_bank", mem_bank, e.bank);
            check("wr_data", mem_din, e.data);
          end
        end else if (prev_wr) begin
          check("wr_release_on_ce", mem_wr, !ce_ref);
        end
      end
      prev_wr = mem_wr;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic push(input logic [22:0] a, input logic b, input logic [7:0] d);
    exp_q.push_back(wr_t'({a, b, d}));
  endtask

  task automatic push_rep(input logic [22:0] a, input logic [7:0] d);
    push(a, 1'b0, d);
    push(a, 1'b1, d);
  endtask

  task automatic start_dl(input logic [7:0] idx, input logic [15:0] ext);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    ioctl_index    = idx;
    ioctl_file_ext = ext;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    check("idle_in_time", n < 300, 1);
    check("wait_released", ioctl_wait, 0);
    check("sb_drained", exp_q.size(), 0);
  endtask

  task automatic pulse_wr(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    pulse_wr(a, d);
    wait_idle();
  endtask

  task automatic check_map(input string tag, input logic [7:0] a, input logic e);
    @(negedge clk_sys);
    map_addr = a;
    @(negedge clk_sys);
    check(tag, map_hit, e);
  endtask

  initial begin
    int n;
    repeat (4) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst_wait", ioctl_wait, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_bank", mem_bank, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_map_hit", map_hit, 0);
    check("rst_busy", busy, 0);

    // Boot image, block 1 -> BASIC page, then bitmap lag of two cycles
    start_dl(8'h00, 16'h0000);
    map_addr = 8'h00;
    push(23'h400005, 1'b0, 8'hA5);
    send(25'h0004005, 8'hA5);
    check("hit_lag", map_hit, 0);
    @(negedge clk_sys);
    check("hit_basic", map_hit, 1);

    // Boot image block 8 is dropped without stall
    pulse_wr(25'h0020000, 8'h11);
    check("drop_no_wait", ioctl_wait, 0);
    check("drop_not_busy", busy, 0);
    wait_idle();

    // Boot image block 7 -> MF2 page, bank 1
    push(23'h7FC001, 1'b1, 8'h5E);
    send(25'h001C001, 8'h5E);

    // Ext "07", replicated over both banks
    start_dl(8'h01, 16'h3037);
    push_rep(23'h41C010, 8'h77);
    send(25'h0000010, 8'h77);
    check_map("hit_p07", 8'h07, 1'b1);
    check_map("miss_p03", 8'h03, 1'b0);

    // Ext "FF": page add wraps
    start_dl(8'h01, 16'h4646);
    push_rep(23'h400000, 8'h12);
    send(25'h0004000, 8'h12);
    push_rep(23'h404123, 8'h13);
    send(25'h0008123, 8'h13);
    check_map("hit_p01", 8'h01, 1'b1);

    // Ext "Z0": first 16 KiB at page 0, then continue from MF2 page
    start_dl(8'h01, 16'h5A30);
    push_rep(23'h000000, 8'h21);
    send(25'h0000000, 8'h21);
    push_rep(23'h003FFF, 8'h22);
    send(25'h0003FFF, 8'h22);
    push_rep(23'h400000, 8'h23);
    send(25'h0004000, 8'h23);
    push_rep(23'h408000, 8'h24);
    send(25'h000C000, 8'h24);
    check_map("hit_p02", 8'h02, 1'b1);

    // Unknown ext, index 0xC0: bad-ext page, single write in bank 1
    start_dl(8'hC0, 16'h7878);
    push(23'h7B8005, 1'b1, 8'h9A);
    send(25'h0000005, 8'h9A);
    check_map("hit_pEE", 8'hEE, 1'b1);

    // Second strobe while busy is ignored
    start_dl(8'h00, 16'h0000);
    push(23'h400010, 1'b0, 8'h3C);
    pulse_wr(25'h0004010, 8'h3C);
    pulse_wr(25'h0000000, 8'hFF);
    wait_idle();

    // Reset in the middle of a write
    push(23'h000033, 1'b0, 8'h44);
    pulse_wr(25'h0000033, 8'h44);
    n = 0;
    while (!mem_wr && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    check("wr_seen_before_reset", mem_wr, 1);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    check("midrst_mem_wr", mem_wr, 0);
    check("midrst_wait", ioctl_wait, 0);
    check("midrst_busy", busy, 0);
    check_map("clr_p00", 8'h00, 1'b0);
    check_map("clr_p07", 8'h07, 1'b0);
    check_map("clr_pEE", 8'hEE, 1'b0);

    // Lowercase digit is not hex: "q7" -> page 0x1E7
    start_dl(8'h01, 16'h7137);
    push_rep(23'h79C123, 8'h5A);
    send(25'h0000123, 8'h5A);
    check_map("hit_pE7", 8'hE7, 1'b1);

    repeat (4) @(negedge clk_sys);
    check("sb_final_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
